// File: rtl/fetch_sequencer.sv
// Multicycle core front end: PC, instruction fetch over req/ack, stage sequencing
// and end-of-instruction next-PC selection with a return-address stack.
module fetch_sequencer #(
  parameter int            AW        = 16,
  parameter int            RAS_DEPTH = 8,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic          instr_valid,
  output logic [2:0]    stage,
  output logic [AW-1:0] pc,
  input  logic [1:0]    branch,
  input  logic          brfl_control,
  input  logic          flag,
  input  logic [AW-1:0] branch_target,
  input  logic          push,
  input  logic          pop,
  input  logic          halt,
  output logic          ras_overflow,
  output logic          ras_underflow,
  output logic          halted
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int PW = IW + 1;

  localparam logic [2:0] S_IFH  = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EX   = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b101;

  localparam logic [31:0] NOP = 32'h0400_0000;

  logic [2:0]    stage_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic          req_q;
  logic [PW-1:0] ptr_q;
  logic          ovf_q;
  logic          unf_q;
  logic [AW-1:0] ras [RAS_DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] ras_wdata;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] ptr_dec;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] ras_widx;
  logic          ras_we;
  logic          set_ovf;
  logic          set_unf;
  logic          go_halt;
  logic          empty;
  logic          full;

  assign pc_inc  = pc_q + AW'(1);
  assign ptr_dec = ptr_q - PW'(1);
  assign top_idx = ptr_dec[IW-1:0];
  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PW'(RAS_DEPTH));

  // Next-PC / RAS decision, only meaningful in WB
  always_comb begin
    pc_nxt    = pc_inc;
    ptr_nxt   = ptr_q;
    ras_we    = 1'b0;
    ras_widx  = ptr_q[IW-1:0];
    ras_wdata = pc_inc;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    go_halt   = 1'b0;
    if (stage_q == S_WB) begin
      if (halt) begin
        go_halt = 1'b1;
        pc_nxt  = pc_q;
      end else if (branch == 2'b01 && push && pop) begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          pc_nxt   = ras[top_idx];
          ras_we   = 1'b1;
          ras_widx = top_idx;
        end
      end else if (branch == 2'b01 && push) begin
        pc_nxt = branch_target;
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          ras_we  = 1'b1;
          ptr_nxt = ptr_q + PW'(1);
        end
      end else if (branch == 2'b01 && pop) begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          pc_nxt  = ras[top_idx];
          ptr_nxt = ptr_dec;
        end
      end else if (branch == 2'b10) begin
        if (!brfl_control || flag) pc_nxt = branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras[ras_widx] <= ras_wdata;
  end

  // The request is registered, so the first IFH cycle after reset only raises it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= S_IFH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      req_q   <= 1'b0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (stage_q)
        S_IFH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            stage_q <= S_ID;
          end
        end
        S_ID:  stage_q <= S_EX;
        S_EX:  stage_q <= S_MEM;
        S_MEM: stage_q <= S_WB;
        S_WB: begin
          pc_q  <= pc_nxt;
          ptr_q <= ptr_nxt;
          ovf_q <= ovf_q | set_ovf;
          unf_q <= unf_q | set_unf;
          if (go_halt) begin
            stage_q <= S_HALT;
          end else begin
            stage_q <= S_IFH;
            req_q   <= 1'b1;
          end
        end
        default: stage_q <= S_HALT;
      endcase
    end
  end

  assign imem_req      = req_q && (stage_q == S_IFH);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:26];
  assign instr_valid   = (stage_q == S_ID) || (stage_q == S_EX) ||
                         (stage_q == S_MEM) || (stage_q == S_WB);
  assign stage         = stage_q;
  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign halted        = (stage_q == S_HALT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the multicycle core. Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Sequences the five execution stages and presents the instruction and opcode to the control unit.
- At the end of each instruction it applies the control unit's branch/push/pop/halt decisions, using an internal return-address stack (RAS) for call/ret.

Parameters:
AW, 16, PC / instruction-memory address width (word addressed)
RAS_DEPTH, 8, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded at reset

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  fetch request, held until ack
imem_addr  output  AW  fetch address (= pc)
imem_ack  input  1  memory has valid data on imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched current instruction
opcode  output  6  instr[31:26]
instr_valid  output  1  instr valid (ID..WB)
stage  output  3  000 IFH, 001 ID, 010 EX, 011 MEM, 100 WB, 101 HALTED
pc  output  AW  current instruction address
branch  input  2  00 seq, 01 call/ret, 10 jump/cond, 11 reserved (seq)
brfl_control  input  1  with branch=10: jump is conditional
flag  input  1  branch condition for brfl
branch_target  input  AW  target for call/jump
push  input  1  call: save return address
pop  input  1  ret: restore return address
halt  input  1  stop fetching
ras_overflow  output  1  sticky: push on full RAS
ras_underflow  output  1  sticky: pop on empty RAS
halted  output  1  core halted

Behaviour:
Reset values (asynchronous):
- pc=RESET_PC, stage=IFH, imem_req=0, instr=32'h0400_0000 (nop), instr_valid=0.
- RAS pointer=0 (empty), RAS contents=0.
- ras_overflow=0, ras_underflow=0, halted=0.
- RAS entries need not be cleared if an implementation prefers, but they are never read when empty.

State machine (one state per stage):
- IFH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, go to ID. Without ack, stay in IFH with req and addr held stable.
- Minimum fetch latency is one cycle (ack in the first IFH cycle).
- ID -> EX -> MEM -> WB: one cycle each. instr_valid=1; instr and pc stable.
- WB: branch/brfl_control/flag/branch_target/push/pop/halt are sampled on the WB clock edge. Next PC is applied and the state returns to IFH (or HALTED).
- imem_req=0 in every state except IFH.

Next-PC priority at WB (first match wins):
1. halt=1: pc unchanged, go to HALTED. halted=1; all other inputs ignored.
2. branch=01, push=1 and pop=1: pc<=RAS top, top entry overwritten with pc+1, pointer unchanged. If empty: behave as case 4 with pop.
3. branch=01, push=1: RAS[ptr]<=pc+1, ptr+1, pc<=branch_target. If full: no write, ptr unchanged, ras_overflow<=1, pc still <=branch_target.
4. branch=01, pop=1: if non-empty, ptr-1, pc<=RAS[ptr-1]. If empty: pc<=pc+1, ras_underflow<=1.
5. branch=10: taken if brfl_control=0 or flag=1. Taken: pc<=branch_target; else pc<=pc+1.
6. Otherwise (00, 11, or 01 with neither push nor pop): pc<=pc+1.

Rules:
- PC arithmetic is modulo 2^AW; all-ones + 1 wraps to 0.
- RAS occupancy spans 0..RAS_DEPTH; full = RAS_DEPTH entries.
- HALTED is left only by reset. imem_req=0, instr_valid=0, stage=101.
- Overflow/underflow flags are sticky until reset.
- Reset mid-fetch (req pending) abandons the fetch; a late ack after reset is ignored because the state is IFH with a fresh request.
- push/pop with branch!=01 are ignored.

Test Plan:
- Reset, ack immediately each fetch, branch=00 -> imem_addr 0,1,2 at IFH; 5-cycle instruction period; opcode=rdata[31:26] during ID..WB.
- Ack delayed 3 cycles at pc=4 -> imem_req high 4 cycles with addr stable at 4; stage stays 000; ID entered the cycle after ack.
- Call at pc=5 (branch=01, push=1, target=0x20), then ret at 0x20 (pop=1) -> pc 0x20, then 6; RAS empty after.
- 9 nested calls with RAS_DEPTH=8 -> ras_overflow=1 on the 9th and pc=target. 9 rets -> first 8 return correctly, 9th gives pc+1 and ras_underflow=1.
- brfl at pc=10 (branch=10, brfl_control=1, target=3): flag=0 -> pc=11; flag=1 -> pc=3. jpc with brfl_control=0 and flag=0 -> taken.
- halt at WB -> stage=101, halted=1, imem_req stays 0 for 20 cycles. Pulse rst_n low mid-IFH at pc=7 -> pc=0, req drops asynchronously, fetch restarts at 0.
